multi_phase_timer: RTL and testbench

- Parametrised periodic multi-phase strobe generator. It is the next generation of the lab2 fixed load/reset divider timer.
- A free-running counter sweeps 0..terminal. Each of NUM_PHASES channels emits a one-cycle registered strobe at its own programmable offset within the sweep.
- Adds run-time period and offsets, continuous or one-shot mode, enable, wrap strobe and asynchronous reset.
- Sits between the board clock and the sequencing logic (register load, accumulator clear, display update) that needs ordered strobes at a slow rate.

---
 rtl/multi_phase_timer_pkg.sv | 27 ++
 rtl/multi_phase_timer_phase_strobe.sv | 28 ++
 rtl/multi_phase_timer.sv | 103 ++++++++++
 tb/tb_multi_phase_timer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_phase_timer_pkg.sv
// Shared types and helpers for the multi-phase strobe timer.
// Holds the sweep state encoding, the reset terminal and the offset slice helper.
package multi_phase_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned TIMER_DEFAULT_TERMINAL = 2_000_000;

  // Widest offset and packed offset vector the slice helper supports.
  localparam int OFS_MAX_W     = 32;
  localparam int OFS_VEC_MAX_W = 1024;

  function automatic logic [OFS_MAX_W-1:0] extract_offset(
    input logic [OFS_VEC_MAX_W-1:0] vec,
    input int unsigned              idx,
    input int unsigned              width
  );
    logic [OFS_MAX_W-1:0] mask;
    if (width >= OFS_MAX_W) mask = '1;
    else                    mask = (OFS_MAX_W'(1) << width) - OFS_MAX_W'(1);
    return OFS_MAX_W'(vec >> (idx * width)) & mask;
  endfunction

endpackage

// File: rtl/multi_phase_timer_phase_strobe.sv
// One strobe channel: registers a single-cycle pulse when the running count
// reaches this channel's offset.
module multi_phase_timer_phase_strobe #(
  parameter int COUNT_WIDTH = 22
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   run,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic [COUNT_WIDTH-1:0] offset,
  output logic                   pulse
);

  logic pulse_d;
  logic pulse_q;

  always_comb begin
    pulse_d = run && (count == offset);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pulse_q <= 1'b0;
    else          pulse_q <= pulse_d;
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/multi_phase_timer.sv
// Periodic multi-phase strobe generator: a counter sweeps 0..terminal and each
// channel fires a registered one-cycle strobe at its own offset in the sweep.
module multi_phase_timer
  import multi_phase_timer_pkg::*;
#(
  parameter int          COUNT_WIDTH      = 22,
  parameter int          NUM_PHASES       = 2,
  parameter int unsigned DEFAULT_TERMINAL = TIMER_DEFAULT_TERMINAL
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              enable,
  input  logic                              oneshot,
  input  logic                              start,
  input  logic [COUNT_WIDTH-1:0]            terminal,
  input  logic [NUM_PHASES*COUNT_WIDTH-1:0] offsets,
  output logic [NUM_PHASES-1:0]             pulse_out,
  output logic                              wrap_out,
  output logic                              busy,
  output logic [COUNT_WIDTH-1:0]            count_out
);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] term_q, term_d;
  logic                   busy_q, busy_d;
  logic                   wrap_q, wrap_d;
  logic                   run;

  assign run = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d  = term_q;
    unique case (state_q)
      IDLE: begin
        if (enable && (!oneshot || start)) begin
          state_d = RUN;
          count_d = '0;
          term_d  = terminal;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q >= term_q) begin
          // Terminal decision: oneshot is sampled here, not at sweep start.
          count_d = '0;
          if (oneshot) state_d = IDLE;
          else         term_d  = terminal;
        end else begin
          count_d = count_q + COUNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    busy_d = (state_d == RUN);
    wrap_d = run && (count_q == term_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      term_q  <= COUNT_WIDTH'(DEFAULT_TERMINAL);
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q  <= term_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  // Offsets are compared live; software only changes them while idle.
  for (genvar i = 0; i < NUM_PHASES; i++) begin : g_phase
    logic [COUNT_WIDTH-1:0] offset_i;
    assign offset_i = COUNT_WIDTH'(extract_offset(OFS_VEC_MAX_W'(offsets), i, COUNT_WIDTH));

    multi_phase_timer_phase_strobe #(
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_strobe (
      .clk    (clk),
      .reset_n(reset_n),
      .run    (run),
      .count  (count_q),
      .offset (offset_i),
      .pulse  (pulse_out[i])
    );
  end

  assign wrap_out  = wrap_q;
  assign busy      = busy_q;
  assign count_out = count_q;

endmodule

// File: tb/tb_multi_phase_timer.sv
// Self-checking bench for multi_phase_timer with an 8-bit counter and two channels.
`timescale 1ns/1ps
module tb_multi_phase_timer;

  localparam int CW = 8;
  localparam int NP = 2;

  logic            clk      = 1'b0;
  logic            reset_n  = 1'b0;
  logic            enable   = 1'b0;
  logic            oneshot  = 1'b0;
  logic            start    = 1'b0;
  logic [CW-1:0]   terminal = 8'd9;
  logic [NP*CW-1:0] offsets = {8'd1, 8'd0};
  logic [NP-1:0]   pulse_out;
  logic            wrap_out;
  logic            busy;
  logic [CW-1:0]   count_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_phase_timer #(
    .COUNT_WIDTH     (CW),
    .NUM_PHASES      (NP),
    .DEFAULT_TERMINAL(200)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .oneshot  (oneshot),
    .start    (start),
    .terminal (terminal),
    .offsets  (offsets),
    .pulse_out(pulse_out),
    .wrap_out (wrap_out),
    .busy     (busy),
    .count_out(count_out)
  );

  typedef struct {
    logic          en;
    logic          os;
    logic          st;
    logic [CW-1:0] term;
    logic [CW-1:0] e_count;
    logic          e_busy;
    logic [NP-1:0] e_pulse;
    logic          e_wrap;
  } vec_t;

  typedef struct {
    logic [CW-1:0] count;
    logic          busy;
    logic [NP-1:0] pulse;
    logic          wrap;
  } obs_t;

  typedef struct {
    int due;
    int ch;
  } ev_t;

  obs_t sbq[$];
  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] snap();
    return 64'({count_out, busy, pulse_out, wrap_out});
  endfunction

  function automatic logic [63:0] pack(input logic [CW-1:0] c, input logic b,
                                       input logic [NP-1:0] p, input logic w);
    return 64'({c, b, p, w});
  endfunction

  function automatic vec_t mk(input logic [CW-1:0] c, input logic [NP-1:0] p, input logic w);
    vec_t v;
    v.en = 1'b1; v.os = 1'b0; v.st = 1'b0; v.term = 8'd9;
    v.e_count = c; v.e_busy = 1'b1; v.e_pulse = p; v.e_wrap = w;
    return v;
  endfunction

  task automatic wait_count(input logic [CW-1:0] v, input int limit, input string name);
    int n;
    n = 0;
    while (count_out !== v && n < limit) begin
      tick();
      n++;
    end
    check(name, 64'(count_out), 64'(v));
  endtask

  // Strobe timing scoreboard: each channel-0 pulse schedules the next one, the
  // channel-1 pulse one cycle later and the wrap strobe period-1 cycles later.
  task automatic monitor(input int period, input int ticks, output int n_p0, output int n_idle);
    ev_t        sb[$];
    bit         armed;
    int         cyc;
    logic [2:0] obs;
    logic [2:0] expv;
    armed = 1'b0; cyc = 0; n_p0 = 0; n_idle = 0;
    repeat (ticks) begin
      tick();
      cyc++;
      obs  = {wrap_out, pulse_out[1], pulse_out[0]};
      expv = '0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due == cyc) begin
          expv[sb[i].ch] = 1'b1;
          sb.delete(i);
        end
      end
      if (armed) check("strobe_timing", 64'(obs), 64'(expv));
      if (busy !== 1'b1) n_idle++;
      if (obs[0]) begin
        armed = 1'b1;
        n_p0++;
        sb.push_back('{cyc + period, 0});
        sb.push_back('{cyc + 1, 1});
        sb.push_back('{cyc + period - 1, 2});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_p0, n_idle, n_p1, n_wrap, n_busy, first_b, last_b, noise, n;
    logic [CW-1:0] maxc;
    obs_t o;

    vecs[0]  = mk(8'd0, 2'b00, 1'b0);
    vecs[1]  = mk(8'd1, 2'b01, 1'b0);
    vecs[2]  = mk(8'd2, 2'b10, 1'b0);
    vecs[3]  = mk(8'd3, 2'b00, 1'b0);
    vecs[4]  = mk(8'd4, 2'b00, 1'b0);
    vecs[5]  = mk(8'd5, 2'b00, 1'b0);
    vecs[6]  = mk(8'd6, 2'b00, 1'b0);
    vecs[7]  = mk(8'd7, 2'b00, 1'b0);
    vecs[8]  = mk(8'd8, 2'b00, 1'b0);
    vecs[9]  = mk(8'd9, 2'b00, 1'b0);
    vecs[10] = mk(8'd0, 2'b00, 1'b1);
    vecs[11] = mk(8'd1, 2'b01, 1'b0);
    vecs[12] = mk(8'd2, 2'b10, 1'b0);

    // Reset state
    repeat (3) tick();
    check("reset_state", snap(), pack(8'd0, 1'b0, 2'b00, 1'b0));
    @(negedge clk);
    reset_n = 1'b1;

    // Table: continuous sweep, terminal 9, offsets {1,0}
    for (int i = 0; i < 13; i++) begin
      enable = vecs[i].en; oneshot = vecs[i].os; start = vecs[i].st; terminal = vecs[i].term;
      sbq.push_back('{vecs[i].e_count, vecs[i].e_busy, vecs[i].e_pulse, vecs[i].e_wrap});
      tick();
      o = sbq.pop_front();
      check($sformatf("table_vec%0d", i), snap(), pack(o.count, o.busy, o.pulse, o.wrap));
    end

    // Steady-state spacing over several sweeps
    monitor(10, 40, n_p0, n_idle);
    check("period10_p0_count", 64'(n_p0), 64'd4);
    check("period10_busy_throughout", 64'(n_idle), 64'd0);

    // Terminal shadowing: change 9 -> 4 at count 3
    wait_count(8'd3, 20, "shadow_wait3");
    terminal = 8'd4;
    maxc = count_out;
    n = 0;
    do begin
      tick();
      n++;
      if (count_out > maxc) maxc = count_out;
    end while (count_out !== 8'd0 && n < 40);
    check("shadow_sweep_end", 64'(maxc), 64'd9);
    monitor(5, 30, n_p0, n_idle);
    check("shadow_p0_count", 64'(n_p0), 64'd6);

    // Enable drop at count 4 in a terminal-9 sweep
    terminal = 8'd9;
    wait_count(8'd4, 20, "endrop_wait4a");
    wait_count(8'd0, 20, "endrop_wait0");
    wait_count(8'd4, 20, "endrop_wait4b");
    enable = 1'b0;
    tick();
    check("endrop_idle", 64'({count_out, busy}), 64'({8'd0, 1'b0}));
    noise = 0;
    repeat (12) begin
      tick();
      if (pulse_out != 2'b00 || wrap_out || busy || count_out != 8'd0) noise++;
    end
    check("endrop_quiet", 64'(noise), 64'd0);
    enable = 1'b1;
    tick();
    check("reenable_c0", snap(), pack(8'd0, 1'b1, 2'b00, 1'b0));
    tick();
    check("reenable_c1", snap(), pack(8'd1, 1'b1, 2'b01, 1'b0));

    // One-shot sweep, terminal 5, with a stray start mid-sweep
    enable = 1'b0;
    tick();
    oneshot = 1'b1; terminal = 8'd5; enable = 1'b1;
    repeat (3) tick();
    check("oneshot_waits_start", 64'(busy), 64'd0);
    start = 1'b1;
    n_busy = 0; n_p0 = 0; n_p1 = 0; n_wrap = 0; first_b = -1; last_b = -1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      start = (t == 3);
      if (busy) begin
        n_busy++;
        if (first_b < 0) first_b = t;
        last_b = t;
      end
      if (pulse_out[0]) n_p0++;
      if (pulse_out[1]) n_p1++;
      if (wrap_out) n_wrap++;
    end
    start = 1'b0;
    check("oneshot_busy_cycles", 64'(n_busy), 64'd6);
    check("oneshot_busy_contig", 64'(last_b - first_b + 1), 64'd6);
    check("oneshot_p0_count", 64'(n_p0), 64'd1);
    check("oneshot_p1_count", 64'(n_p1), 64'd1);
    check("oneshot_wrap_count", 64'(n_wrap), 64'd1);
    check("oneshot_ends_idle", 64'(busy), 64'd0);

    // Offset beyond terminal never fires
    oneshot = 1'b0; terminal = 8'd5; offsets = {8'd7, 8'd0};
    n_p0 = 0; n_p1 = 0;
    repeat (30) begin
      tick();
      if (pulse_out[0]) n_p0++;
      if (pulse_out[1]) n_p1++;
    end
    check("ofs7_never_fires", 64'(n_p1), 64'd0);
    check("ofs7_p0_count", 64'(n_p0), 64'd5);

    // Terminal 0 continuous
    enable = 1'b0;
    tick();
    terminal = 8'd0; offsets = {8'd1, 8'd0}; enable = 1'b1;
    tick();
    check("term0_start", snap(), pack(8'd0, 1'b1, 2'b00, 1'b0));
    for (int t = 0; t < 8; t++) begin
      tick();
      check($sformatf("term0_cycle%0d", t), snap(), pack(8'd0, 1'b1, 2'b01, 1'b1));
    end

    // Asynchronous reset mid-sweep at count 6
    enable = 1'b0;
    tick();
    terminal = 8'd9; enable = 1'b1;
    wait_count(8'd6, 20, "rst_wait6");
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_clear", snap(), pack(8'd0, 1'b0, 2'b00, 1'b0));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_reset_c0", snap(), pack(8'd0, 1'b1, 2'b00, 1'b0));
    tick();
    check("post_reset_c1", snap(), pack(8'd1, 1'b1, 2'b01, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
